lpc_mem_target: RTL

// - LPC peripheral side for memory cycles: decodes the host START/CYCTYPE/ADDR frame and drives TAR, SYNC and read data on LAD.
// - Bridges each decoded cycle to a simple req/ack back-end, such as an on-chip SRAM or a register file.
// - Pairs with our LPC host block, so the bench runs host <-> target back to back on one lclk.

---
 rtl/lpc_mem_target_pkg.sv | 30 +++
 rtl/lpc_sync_timer.sv | 29 ++
 rtl/lpc_mem_target.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/lpc_mem_target_pkg.sv
// Shared LPC frame constants and target FSM state encoding.
// The LPC host block imports the same definitions, so both sides agree on frame nibbles.
package lpc_mem_target_pkg;

  localparam logic [3:0] LPC_START   = 4'h0;
  localparam logic [1:0] CYCTYPE_MEM = 2'b01;
  localparam logic [3:0] SYNC_READY  = 4'h0;
  localparam logic [3:0] SYNC_LWAIT  = 4'h6;
  localparam logic [3:0] SYNC_ERROR  = 4'hA;
  localparam logic [3:0] TAR_DRIVE   = 4'hF;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CYC    = 4'd1,
    ST_ADDR   = 4'd2,
    ST_WDATA  = 4'd3,
    ST_HTAR   = 4'd4,
    ST_SYNC   = 4'd5,
    ST_RDATA  = 4'd6,
    ST_TTAR   = 4'd7,
    ST_IGNORE = 4'd8
  } lpc_state_e;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/lpc_sync_timer.sv
// Saturating count of LWAIT SYNC cycles driven in the current frame.
// The timeout flag rises once TIMEOUT wait cycles have been issued.
module lpc_sync_timer #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT);

  logic [7:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_timeout = (r_count >= LP_LIMIT);

endmodule

// File: rtl/lpc_mem_target.sv
// LPC memory-cycle target: decodes host frames, drives TAR/SYNC/read data on LAD,
// and hands each decoded cycle to a req/ack back-end.
module lpc_mem_target
  import lpc_mem_target_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK    = 32'hFFFF_0000,
  parameter int unsigned SYNC_TIMEOUT = 8
) (
  input  logic        lclk,
  input  logic        lreset_n,
  input  logic [3:0]  lad_in,
  output logic [3:0]  lad_out,
  output logic        lad_oe,
  input  logic        lframe,
  output logic        be_req,
  output logic        be_wr,
  output logic [31:0] be_addr,
  output logic [7:0]  be_wdata,
  input  logic [7:0]  be_rdata,
  input  logic        be_ack
);

  lpc_state_e  r_state, w_state_next;
  logic [2:0]  r_cnt, w_cnt_next;
  logic        r_dir, w_dir_next;
  logic [31:0] r_addr, w_addr_next;
  logic [7:0]  r_wdata, w_wdata_next;
  logic [7:0]  r_rdata, w_rdata_next;
  logic        r_req, w_req_next;
  logic        r_wr, w_wr_next;
  logic        r_ack, w_ack_next;
  logic [3:0]  r_lad_out, w_lad_out_next;
  logic        r_lad_oe, w_lad_oe_next;
  logic        w_ack_in, w_ok, w_timeout, w_tmr_clr, w_tmr_en;
  logic [31:0] w_addr_full;

  lpc_sync_timer #(.TIMEOUT(SYNC_TIMEOUT)) u_sync_timer (
    .i_clk    (lclk),
    .i_rst_n  (lreset_n),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_timeout(w_timeout)
  );

  // An ack only counts while a request is outstanding.
  assign w_ack_in    = be_ack & r_req;
  assign w_ok        = r_ack | w_ack_in;
  assign w_addr_full = {r_addr[27:0], lad_in};

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_dir_next     = r_dir;
    w_addr_next    = r_addr;
    w_wdata_next   = r_wdata;
    w_rdata_next   = r_rdata;
    w_req_next     = r_req;
    w_wr_next      = r_wr;
    w_ack_next     = r_ack;
    w_lad_out_next = TAR_DRIVE;
    w_lad_oe_next  = 1'b0;
    w_tmr_clr      = 1'b0;
    w_tmr_en       = 1'b0;

    if (w_ack_in) begin
      w_req_next = 1'b0;
      w_ack_next = 1'b1;
      if (!r_wr) w_rdata_next = be_rdata;
    end

    if ((r_state != ST_IDLE) && !lframe) begin
      w_state_next = (lad_in == LPC_START) ? ST_CYC : ST_IDLE;
      w_req_next   = 1'b0;
      w_ack_next   = 1'b0;
      w_tmr_clr    = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!lframe && (lad_in == LPC_START)) w_state_next = ST_CYC;
        end
        ST_CYC: begin
          if ((lad_in[3:2] == CYCTYPE_MEM) && !lad_in[0]) begin
            w_dir_next   = lad_in[1];
            w_cnt_next   = 3'd7;
            w_state_next = ST_ADDR;
          end else begin
            w_state_next = ST_IGNORE;
          end
        end
        ST_ADDR: begin
          w_addr_next = w_addr_full;
          w_cnt_next  = r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            if (!addr_hit(w_addr_full, ADDR_BASE, ADDR_MASK)) begin
              w_state_next = ST_IGNORE;
            end else if (r_dir) begin
              w_state_next = ST_WDATA;
              w_cnt_next   = 3'd1;
            end else begin
              w_state_next = ST_HTAR;
              w_cnt_next   = 3'd1;
              w_req_next   = 1'b1;
              w_wr_next    = 1'b0;
              w_ack_next   = 1'b0;
              w_tmr_clr    = 1'b1;
            end
          end
        end
        ST_WDATA: begin
          if (r_cnt == 3'd1) begin
            w_wdata_next[3:0] = lad_in;
            w_cnt_next        = 3'd0;
          end else begin
            w_wdata_next[7:4] = lad_in;
            w_state_next      = ST_HTAR;
            w_cnt_next        = 3'd1;
            w_req_next        = 1'b1;
            w_wr_next         = 1'b1;
            w_ack_next        = 1'b0;
            w_tmr_clr         = 1'b1;
          end
        end
        ST_HTAR: begin
          if (r_cnt == 3'd1) begin
            w_cnt_next = 3'd0;
          end else begin
            w_state_next  = ST_SYNC;
            w_lad_oe_next = 1'b1;
            if (w_ok) begin
              w_lad_out_next = SYNC_READY;
            end else begin
              w_lad_out_next = SYNC_LWAIT;
              w_tmr_en       = 1'b1;
            end
          end
        end
        ST_SYNC: begin
          w_lad_oe_next = 1'b1;
          // The nibble on LAD this cycle tells whether SYNC has finished.
          if (r_lad_out == SYNC_READY) begin
            w_cnt_next = 3'd1;
            if (r_dir) begin
              w_state_next = ST_TTAR;
            end else begin
              w_state_next   = ST_RDATA;
              w_lad_out_next = r_rdata[3:0];
            end
          end else if (r_lad_out == SYNC_ERROR) begin
            w_state_next = ST_TTAR;
            w_cnt_next   = 3'd1;
          end else if (w_ok) begin
            w_lad_out_next = SYNC_READY;
          end else if (!w_timeout) begin
            w_lad_out_next = SYNC_LWAIT;
            w_tmr_en       = 1'b1;
          end else begin
            w_lad_out_next = SYNC_ERROR;
            w_req_next     = 1'b0;
          end
        end
        ST_RDATA: begin
          w_lad_oe_next = 1'b1;
          if (r_cnt == 3'd1) begin
            w_lad_out_next = r_rdata[7:4];
            w_cnt_next     = 3'd0;
          end else begin
            w_state_next = ST_TTAR;
            w_cnt_next   = 3'd1;
          end
        end
        ST_TTAR: begin
          if (r_cnt == 3'd1) begin
            w_cnt_next = 3'd0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_IGNORE: begin
          w_state_next = ST_IGNORE;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 3'd0;
      r_dir     <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 8'd0;
      r_rdata   <= 8'd0;
      r_req     <= 1'b0;
      r_wr      <= 1'b0;
      r_ack     <= 1'b0;
      r_lad_out <= TAR_DRIVE;
      r_lad_oe  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_dir     <= w_dir_next;
      r_addr    <= w_addr_next;
      r_wdata   <= w_wdata_next;
      r_rdata   <= w_rdata_next;
      r_req     <= w_req_next;
      r_wr      <= w_wr_next;
      r_ack     <= w_ack_next;
      r_lad_out <= w_lad_out_next;
      r_lad_oe  <= w_lad_oe_next;
    end
  end

  assign lad_out  = r_lad_out;
  assign lad_oe   = r_lad_oe;
  assign be_req   = r_req;
  assign be_wr    = r_wr;
  assign be_addr  = r_addr;
  assign be_wdata = r_wdata;

endmodule
